inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage directly upstream of the IF/ID pipeline register. Owns the fetch PC, issues word reads to instruction memory over a req/ack handshake tolerating any number of wait states, buffers returned instructions in a small FIFO, and presents `{pc, inst, valid}` to IF/ID. Honours a downstream stall and a branch redirect from decode.

## Interface
- `RESET_PC`: default 32'h0000_0000; first fetch address after reset.
- `DEPTH`: default 2; fetch buffer entries (≥2).

Ports:
- `clk` in, 1: single clock, all state on rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `stall_i` in, 1: IF/ID cannot accept this cycle.
- `branch_flag_i` in, 1: redirect fetch this cycle.
- `branch_target_i` in, 32: redirect address; bits [1:0] forced to 0.
- `imem_req_o` out, 1: read request.
- `imem_addr_o` out, 32: word address of request.
- `imem_ack_i` in, 1: data valid and request complete this cycle.
- `imem_rdata_i` in, 32: instruction word, valid when ack.
- `if_pc` out, 32: PC of head entry, 0 when invalid.
- `if_inst` out, 32: instruction of head entry, 0 (NOP) when invalid.
- `if_valid` out, 1: head entry present.

## Operation
- Registers: `req_addr` (drives `imem_addr_o`), FIFO of `{pc, inst}` with `count`, `discard` flag, `redirect_pc`.
- `imem_req_o = !rst && (count < DEPTH || discard)`, combinational from registered state. Once raised, it stays high with `imem_addr_o` stable until ack. Pops only lower `count`; `req_addr` is never changed while a request is unacked.
- Ack with `discard=0` and no branch: push `{req_addr, imem_rdata_i}`; `req_addr += 4`, wrapping 32'hFFFF_FFFC → 0.
- Ack with `discard=1`: drop data, clear `discard`, `req_addr <= redirect_pc`.
- Pop: when `if_valid && !stall_i` at the edge. Push and pop in the same cycle leave `count` unchanged. Push never overflows because a request only starts with `count < DEPTH`.
- `if_valid = (count != 0)`. `if_pc` and `if_inst` show the FIFO head, or 0 when empty.
- Branch (`branch_flag_i=1`) takes priority over push:
  - The head transfer in the branch cycle still completes if `!stall_i`.
  - Then the whole FIFO is flushed (`count <= 0`).
  - If `imem_req_o=0`, or ack arrives this cycle: `req_addr <= target`, `discard <= 0`, and any same-cycle ack data is dropped.
  - Else (request pending, no ack): `redirect_pc <= target`, `discard <= 1`.
  - A second branch while `discard=1` only overwrites `redirect_pc`.
- Reset outputs: `imem_req_o=0`, `imem_addr_o=RESET_PC`, `if_valid=0`, `if_pc=0`, `if_inst=0`. Also `count=0`, `discard=0`, `req_addr=RESET_PC`. Reset mid-request abandons it; memory must tolerate req dropping.

## Timing
- `rst` low at edge E0 → `imem_req_o=1`, addr `RESET_PC` in the cycle after E0.
- Zero-wait memory (ack in same cycle as req): data pushed at edge E1, `if_valid=1` after E1. Fetch-to-IF/ID latency is 1 cycle plus wait states.
- Steady state with zero-wait memory and no stall: one instruction per cycle, PCs consecutive.
- With `stall_i` held, fetch continues until `count == DEPTH`, then `imem_req_o` deasserts the cycle after the last push. It reasserts the cycle after the first pop.
- Redirect with no pending request: target requested in the next cycle. Instruction at target reaches `if_valid` no earlier than 2 cycles after the branch cycle.
- A stale in-flight response costs its remaining wait states plus one cycle.

## Test plan
- **Reset/stream**: `RESET_PC=0`, ack every cycle with `rdata = addr ^ 32'hA5A5_0000`, no stall → `if_pc` sequence 0, 4, 8, 12… one per cycle with matching `if_inst`; all outputs 0 and `imem_req_o=0` while `rst=1`.
- **Wait states**: ack 3 cycles after each req → `imem_addr_o` stable while waiting; `if_valid` pulses once per 3 cycles; no duplicated or skipped PC.
- **Stall/backpressure**: stall 5 cycles from steady state → exactly `DEPTH` (2) entries buffered, `imem_req_o=0`, `if_pc` held. After release, PCs continue contiguous with no loss.
- **Branch, idle memory**: branch to 32'h0000_0103 while the FIFO holds 2 entries → FIFO flushed, next request addr 32'h0000_0100, next valid `if_pc=32'h100`.
- **Branch during pending request**: request at 32'h40 waiting, branch to 32'h200, ack 2 cycles later → 32'h40 data never appears on `if_*`, next request 32'h200. A second branch to 32'h300 before the ack → 32'h300 wins.
- **Wrap/reset mid-op**: branch to 32'hFFFF_FFF8 → PCs FFFF_FFF8, FFFF_FFFC, 0000_0000. Asserting `rst` with a request outstanding → next-cycle outputs all reset values, restart at `RESET_PC`.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage feeding the IF/ID register.
// Owns the fetch PC, talks req/ack to imem and buffers fetched words.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   req_addr;
    logic [31:0]   redirect_pc;
    logic [31:0]   buf_pc   [DEPTH];
    logic [31:0]   buf_inst [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          discard;

    logic          full;
    logic          ack;
    logic          push;
    logic          pop;
    logic [31:0]   target;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full        = (count == CW'(DEPTH));
    assign imem_req_o  = !rst && (!full || discard);
    assign imem_addr_o = req_addr;
    assign ack         = imem_req_o && imem_ack_i;
    assign pop         = if_valid && !stall_i;
    assign push        = ack && !discard && !branch_flag_i;
    assign target      = branch_target_i & ~32'h3;

    assign if_valid = (count != '0);
    assign if_pc    = if_valid ? buf_pc[rd_ptr] : '0;
    assign if_inst  = if_valid ? buf_inst[rd_ptr] : '0;

    // Fetch PC, redirect bookkeeping and FIFO occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr    <= RESET_PC;
            redirect_pc <= RESET_PC;
            discard     <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (branch_flag_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            if (!imem_req_o || ack) begin
                req_addr <= target;
                discard  <= 1'b0;
            end else begin
                redirect_pc <= target;
                discard     <= 1'b1;
            end
        end else begin
            if (ack && discard) begin
                discard  <= 1'b0;
                req_addr <= redirect_pc;
            end
            if (push) begin
                req_addr <= req_addr + 32'd4;
                wr_ptr   <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Buffer storage; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]   <= req_addr;
            buf_inst[wr_ptr] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch.
// Memory model with programmable wait states and a PC scoreboard.
module tb_inst_fetch;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    int checks = 0;
    int failures = 0;
    int mem_wait = 0;
    int mem_cnt = 0;
    bit mem_hold = 1'b0;

    logic [31:0] exp_q[$];
    logic [31:0] obs_pc_q[$];
    logic [31:0] obs_inst_q[$];

    inst_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_rdata_i    (imem_rdata_i),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .if_valid        (if_valid)
    );

    always #5 clk = ~clk;

    // One clock: memory answers at negedge, IF/ID transfers are logged.
    task automatic cycle();
        @(negedge clk);
        if (imem_req_o !== 1'b1) begin
            imem_ack_i = 1'b0;
            mem_cnt = 0;
        end else if (mem_hold) begin
            imem_ack_i = 1'b0;
        end else if (mem_cnt >= mem_wait) begin
            imem_ack_i = 1'b1;
            imem_rdata_i = imem_addr_o ^ KEY;
            mem_cnt = 0;
        end else begin
            imem_ack_i = 1'b0;
            mem_cnt++;
        end
        if (if_valid === 1'b1 && stall_i === 1'b0) begin
            obs_pc_q.push_back(if_pc);
            obs_inst_q.push_back(if_inst);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stall_i = 1'b0;
        branch_flag_i = 1'b0;
        rst = 1'b1;
        cycle();
        cycle();
        mem_hold = 1'b0;
        mem_wait = 0;
        mem_cnt = 0;
        exp_q.delete();
        obs_pc_q.delete();
        obs_inst_q.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0 ||
                if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
                failures++;
                $display("FAIL reset_out req=%b addr=%h v=%b pc=%h inst=%h want all 0",
                         imem_req_o, imem_addr_o, if_valid, if_pc, if_inst);
            end
        end
        mem_wait = 0;
        mem_cnt = 0;
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL first_req req=%b addr=%h v=%b want 1 00000000 0",
                     imem_req_o, imem_addr_o, if_valid);
        end
        cycle();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== KEY) begin
            failures++;
            $display("FAIL first_data v=%b pc=%h inst=%h want 1 00000000 %h",
                     if_valid, if_pc, if_inst, KEY);
        end
    endtask

    task automatic test_stream();
        logic [31:0] e, p, i;
        do_reset();
        for (int k = 0; k < 20; k++) exp_q.push_back(32'(4 * k));
        for (int k = 0; k < 21; k++) cycle();
        while (exp_q.size() > 0 && obs_pc_q.size() > 0) begin
            e = exp_q.pop_front();
            p = obs_pc_q.pop_front();
            i = obs_inst_q.pop_front();
            checks++;
            if (p !== e || i !== (e ^ KEY)) begin
                failures++;
                $display("FAIL stream pc=%h inst=%h want %h %h", p, i, e, e ^ KEY);
            end
        end
        checks++;
        if (exp_q.size() != 0 || obs_pc_q.size() != 0) begin
            failures++;
            $display("FAIL stream_len exp_left=%0d obs_left=%0d want 0 0",
                     exp_q.size(), obs_pc_q.size());
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] e, p, i, a;
        logic r;
        do_reset();
        mem_wait = 2;
        for (int k = 0; k < 10; k++) exp_q.push_back(32'(4 * k));
        for (int k = 0; k < 31; k++) begin
            a = imem_addr_o;
            r = imem_req_o;
            cycle();
            if (r && !imem_ack_i) begin
                checks++;
                if (imem_addr_o !== a || imem_req_o !== 1'b1) begin
                    failures++;
                    $display("FAIL wait_addr req=%b addr=%h want 1 %h", imem_req_o, imem_addr_o, a);
                end
            end
        end
        while (exp_q.size() > 0 && obs_pc_q.size() > 0) begin
            e = exp_q.pop_front();
            p = obs_pc_q.pop_front();
            i = obs_inst_q.pop_front();
            checks++;
            if (p !== e || i !== (e ^ KEY)) begin
                failures++;
                $display("FAIL wait_stream pc=%h inst=%h want %h %h", p, i, e, e ^ KEY);
            end
        end
        checks++;
        if (exp_q.size() != 0 || obs_pc_q.size() != 0) begin
            failures++;
            $display("FAIL wait_len exp_left=%0d obs_left=%0d want 0 0",
                     exp_q.size(), obs_pc_q.size());
        end
    endtask

    task automatic test_stall();
        logic [31:0] e, p, i;
        do_reset();
        for (int k = 0; k < 12; k++) exp_q.push_back(32'(4 * k));
        for (int k = 0; k < 5; k++) cycle();
        stall_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            checks++;
            if (imem_req_o !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h10) begin
                failures++;
                $display("FAIL stall_hold req=%b v=%b pc=%h want 0 1 00000010",
                         imem_req_o, if_valid, if_pc);
            end
        end
        stall_i = 1'b0;
        cycle();
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h18) begin
            failures++;
            $display("FAIL stall_rereq req=%b addr=%h want 1 00000018", imem_req_o, imem_addr_o);
        end
        for (int k = 0; k < 7; k++) cycle();
        while (exp_q.size() > 0 && obs_pc_q.size() > 0) begin
            e = exp_q.pop_front();
            p = obs_pc_q.pop_front();
            i = obs_inst_q.pop_front();
            checks++;
            if (p !== e || i !== (e ^ KEY)) begin
                failures++;
                $display("FAIL stall_stream pc=%h inst=%h want %h %h", p, i, e, e ^ KEY);
            end
        end
        checks++;
        if (exp_q.size() != 0 || obs_pc_q.size() != 0) begin
            failures++;
            $display("FAIL stall_len exp_left=%0d obs_left=%0d want 0 0",
                     exp_q.size(), obs_pc_q.size());
        end
    endtask

    task automatic test_branch_idle();
        logic [31:0] e, p, i;
        do_reset();
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        checks++;
        if (imem_req_o !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0) begin
            failures++;
            $display("FAIL bri_full req=%b v=%b pc=%h want 0 1 00000000",
                     imem_req_o, if_valid, if_pc);
        end
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_0103;
        cycle();
        branch_flag_i = 1'b0;
        stall_i = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
            failures++;
            $display("FAIL bri_flush v=%b req=%b addr=%h want 0 1 00000100",
                     if_valid, imem_req_o, imem_addr_o);
        end
        for (int k = 0; k < 4; k++) exp_q.push_back(32'h100 + 32'(4 * k));
        for (int k = 0; k < 5; k++) cycle();
        while (exp_q.size() > 0 && obs_pc_q.size() > 0) begin
            e = exp_q.pop_front();
            p = obs_pc_q.pop_front();
            i = obs_inst_q.pop_front();
            checks++;
            if (p !== e || i !== (e ^ KEY)) begin
                failures++;
                $display("FAIL bri_stream pc=%h inst=%h want %h %h", p, i, e, e ^ KEY);
            end
        end
        checks++;
        if (exp_q.size() != 0 || obs_pc_q.size() != 0) begin
            failures++;
            $display("FAIL bri_len exp_left=%0d obs_left=%0d want 0 0",
                     exp_q.size(), obs_pc_q.size());
        end
    endtask

    task automatic test_branch_pending();
        logic [31:0] e, p, i, want;
        for (int pass = 0; pass < 2; pass++) begin
            want = (pass == 0) ? 32'h200 : 32'h300;
            do_reset();
            stall_i = 1'b1;
            cycle();
            cycle();
            mem_hold = 1'b1;
            branch_flag_i = 1'b1;
            branch_target_i = 32'h40;
            cycle();
            branch_flag_i = 1'b0;
            stall_i = 1'b0;
            cycle();
            branch_flag_i = 1'b1;
            branch_target_i = 32'h200;
            cycle();
            branch_flag_i = 1'b0;
            checks++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40 || if_valid !== 1'b0) begin
                failures++;
                $display("FAIL brp_pend req=%b addr=%h v=%b want 1 00000040 0",
                         imem_req_o, imem_addr_o, if_valid);
            end
            if (pass == 1) begin
                branch_flag_i = 1'b1;
                branch_target_i = 32'h300;
            end
            cycle();
            branch_flag_i = 1'b0;
            mem_hold = 1'b0;
            cycle();
            checks++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== want || if_valid !== 1'b0) begin
                failures++;
                $display("FAIL brp_redir req=%b addr=%h v=%b want 1 %h 0",
                         imem_req_o, imem_addr_o, if_valid, want);
            end
            for (int k = 0; k < 3; k++) exp_q.push_back(want + 32'(4 * k));
            for (int k = 0; k < 4; k++) cycle();
            while (exp_q.size() > 0 && obs_pc_q.size() > 0) begin
                e = exp_q.pop_front();
                p = obs_pc_q.pop_front();
                i = obs_inst_q.pop_front();
                checks++;
                if (p !== e || i !== (e ^ KEY)) begin
                    failures++;
                    $display("FAIL brp_stream pc=%h inst=%h want %h %h", p, i, e, e ^ KEY);
                end
            end
            checks++;
            if (exp_q.size() != 0 || obs_pc_q.size() != 0) begin
                failures++;
                $display("FAIL brp_len exp_left=%0d obs_left=%0d want 0 0",
                         exp_q.size(), obs_pc_q.size());
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e, p, i;
        do_reset();
        branch_flag_i = 1'b1;
        branch_target_i = 32'hFFFF_FFF8;
        cycle();
        branch_flag_i = 1'b0;
        checks++;
        if (imem_addr_o !== 32'hFFFF_FFF8 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL wrap_redir addr=%h v=%b want fffffff8 0", imem_addr_o, if_valid);
        end
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        for (int k = 0; k < 5; k++) cycle();
        while (exp_q.size() > 0 && obs_pc_q.size() > 0) begin
            e = exp_q.pop_front();
            p = obs_pc_q.pop_front();
            i = obs_inst_q.pop_front();
            checks++;
            if (p !== e || i !== (e ^ KEY)) begin
                failures++;
                $display("FAIL wrap_stream pc=%h inst=%h want %h %h", p, i, e, e ^ KEY);
            end
        end
        checks++;
        if (exp_q.size() != 0 || obs_pc_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_len exp_left=%0d obs_left=%0d want 0 0",
                     exp_q.size(), obs_pc_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] e, p, i;
        do_reset();
        for (int k = 0; k < 3; k++) cycle();
        mem_hold = 1'b1;
        cycle();
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hC) begin
            failures++;
            $display("FAIL rstm_pend req=%b addr=%h want 1 0000000c", imem_req_o, imem_addr_o);
        end
        rst = 1'b1;
        cycle();
        checks++;
        if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0 ||
            if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
            failures++;
            $display("FAIL rstm_out req=%b addr=%h v=%b pc=%h inst=%h want all 0",
                     imem_req_o, imem_addr_o, if_valid, if_pc, if_inst);
        end
        rst = 1'b0;
        mem_hold = 1'b0;
        #1;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL rstm_restart req=%b addr=%h want 1 00000000", imem_req_o, imem_addr_o);
        end
        for (int k = 0; k < 3; k++) exp_q.push_back(32'(4 * k));
        for (int k = 0; k < 3; k++) exp_q.push_back(32'(4 * k));
        for (int k = 0; k < 4; k++) cycle();
        while (exp_q.size() > 0 && obs_pc_q.size() > 0) begin
            e = exp_q.pop_front();
            p = obs_pc_q.pop_front();
            i = obs_inst_q.pop_front();
            checks++;
            if (p !== e || i !== (e ^ KEY)) begin
                failures++;
                $display("FAIL rstm_stream pc=%h inst=%h want %h %h", p, i, e, e ^ KEY);
            end
        end
        checks++;
        if (exp_q.size() != 0 || obs_pc_q.size() != 0) begin
            failures++;
            $display("FAIL rstm_len exp_left=%0d obs_left=%0d want 0 0",
                     exp_q.size(), obs_pc_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wait_states();
        test_stall();
        test_branch_idle();
        test_branch_pending();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
